// File: rtl/ccg_sweep_ctrl.sv
// ccg_sweep_ctrl: exhaustive truth-table sweep with golden compare, first-fail capture and response signature
module ccg_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             golden_we,
    input  logic [N_IN-1:0]  golden_addr,
    input  logic [N_OUT-1:0] golden_data,
    output logic [N_IN-1:0]  dut_x,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    fail_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid,
    output logic [15:0]      signature
);
    localparam int CW = $clog2(SETTLE + 1);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [N_OUT-1:0] golden [2**N_IN];
    logic miss, last;
    logic [N_IN:0] fail_n;
    logic [15:0] sig_n;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign last = &dut_x;
    assign miss = dut_f != golden[dut_x];
    assign fail_n = fail_count + (N_IN+1)'(miss);
    assign sig_n = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ 16'(dut_f);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? DRIVE : IDLE;
            DRIVE:   state_n = cnt == CW'(1) ? SAMPLE : DRIVE;
            SAMPLE:  state_n = last ? DONE : DRIVE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            dut_x            <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            signature        <= '0;
            for (int i = 0; i < 2**N_IN; i++) golden[i] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && golden_we) golden[golden_addr] <= golden_data;
            if (state == IDLE && start) begin
                dut_x            <= '0;
                cnt              <= CW'(SETTLE);
                pass             <= 1'b0;
                fail_count       <= '0;
                first_fail_vec   <= '0;
                first_fail_valid <= 1'b0;
                signature        <= '0;
            end
            if (state == DRIVE) cnt <= cnt - CW'(1);
            if (state == SAMPLE) begin
                fail_count <= fail_n;
                signature  <= sig_n;
                if (miss && !first_fail_valid) begin
                    first_fail_vec   <= dut_x;
                    first_fail_valid <= 1'b1;
                end
                // pass is settled on the last sample so it is already valid during the done pulse
                if (last) pass <= fail_n == '0;
                else begin
                    dut_x <= dut_x + N_IN'(1);
                    cnt   <= CW'(SETTLE);
                end
            end
        end
    end
endmodule
